// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: start-up gating,
// load-use interlock, branch/jump redirect and data-memory wait with timeout.
//
// Data-memory handshake: dmem_req_i is held high by the MEM stage for as long
// as it holds a lw/sw; the access completes in the cycle where dmem_req_i and
// dmem_ack_i are both high. Every cycle with req high and ack low is a wait
// cycle in which the whole pipeline is frozen.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic [1:0]       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              load_use, mem_stall, redirect, active;

    assign load_use  = idex_memread_i && (idex_rt_i != 5'd0) &&
                       ((idex_rt_i == ifid_rs_i) ||
                        (id_uses_rt_i && (idex_rt_i == ifid_rt_i)));
    assign mem_stall = dmem_req_i && !dmem_ack_i;
    assign redirect  = branch_taken_i || jump_i;
    assign active    = (state_q == S_RUN) || (state_q == S_MEM_WAIT);

    assign state_o = state_q;
    assign err_o   = err_q;

    // State register with wait counter and sticky timeout error
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state: start gating, memory wait tracking and timeout to HALT
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (mem_stall) begin
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end
            end
            default: begin
                // HALT is left only through reset
                state_d = S_HALT;
            end
        endcase
    end

    // Pipeline register controls: mem freeze > load-use > redirect > flow
    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_write_o  = 1'b1;
        memwb_bubble_o = 1'b0;
        if (state_q == S_IDLE) begin
            // Hold fetch, keep feeding nops down the back half
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if ((state_q == S_HALT) || mem_stall) begin
            // Full freeze; MEM/WB gets a nop so WB does not repeat
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (load_use) begin
            // Branch operands are not valid yet, so redirect waits a cycle
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (redirect) begin
            ifid_flush_o = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (active && (mem_stall || load_use) && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (ifid_flush_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline. It sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) around three events: start-up gating, load-use hazards, and branch/jump redirects. It also handles multi-cycle data-memory accesses (req/ack handshake) with a timeout. It exports saturating stall and flush cycle counters for the bench's performance report.

Parameters:
CNT_W, 32, width of stall/flush counters
MEM_TIMEOUT, 16, maximum consecutive wait cycles on a data-memory access before error

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-low reset
start_i  in  1  run enable; first high level starts the pipeline
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  load destination register in EX
ifid_rs_i  in  5  rs of instruction in ID
ifid_rt_i  in  5  rt of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt as a source
branch_taken_i  in  1  branch resolved taken in ID
jump_i  in  1  jump decoded in ID
dmem_req_i  in  1  MEM stage holds lw/sw
dmem_ack_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clear to nop
idex_write_o  out  1  ID/EX load enable
idex_bubble_o  out  1  ID/EX load nop (control zeroed)
exmem_write_o  out  1  EX/MEM load enable
memwb_bubble_o  out  1  MEM/WB load nop
state_o  out  2  0=IDLE 1=RUN 2=MEM_WAIT 3=HALT
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  stall cycle count
flush_cnt_o  out  CNT_W  flush cycle count

Behaviour:
- Reset (rst_i=0 at clock edge): state=IDLE, counters=0, err_o=0, wait counter=0. Outputs are combinational from state and inputs.
- IDLE:
  - pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_write=1, memwb_bubble=0, ifid_flush=0.
  - Moves to RUN on the first edge with start_i=1.
  - After entering RUN, start_i is ignored until reset.
- Derived terms:
  - load_use = idex_memread_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | (id_uses_rt_i & idex_rt_i==ifid_rt_i)).
  - mem_stall = dmem_req_i & ~dmem_ack_i.
- Priority in RUN/MEM_WAIT: mem_stall > load_use > redirect (branch_taken_i | jump_i).
- mem_stall:
  - pc/ifid/idex/exmem write=0, memwb_bubble=1, idex_bubble=0, ifid_flush=0.
  - Pending redirect and load_use are not acted on. They reappear because ID is frozen.
- load_use (no mem_stall):
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - branch_taken_i/jump_i are ignored that cycle (operands not yet valid).
- Redirect (neither stall):
  - ifid_flush=1, pc_write=1, ifid_write=1.
  - Exactly one bubble per taken branch/jump.
- Otherwise all write enables=1, bubbles/flush=0.
- RUN -> MEM_WAIT when mem_stall. Wait counter is set to 1.
- MEM_WAIT:
  - Wait counter increments each mem_stall cycle.
  - If dmem_ack_i=1 (or dmem_req_i drops), the freeze releases combinationally that same cycle and the next state is RUN.
  - If mem_stall persists and wait counter == MEM_TIMEOUT, the next state is HALT and err_o is set.
- HALT: same freeze as mem_stall; exited only by reset.
- stall_cnt += 1 each cycle in RUN/MEM_WAIT where mem_stall or load_use is active. IDLE and HALT cycles are not counted.
- flush_cnt += 1 each cycle with ifid_flush_o=1.
- Both counters saturate at all-ones (no wrap).
- Reset mid-MEM_WAIT or in HALT returns to IDLE, clears err_o and the counters, and discards the pending access.

Test Plan:
1. Reset 2 cycles, start_i=0 for 3 cycles -> state_o=0, pc_write_o=0, idex_bubble_o=1, counters 0. Raise start_i -> state_o=1 next edge, pc_write_o=1.
2. RUN, idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for 1 cycle -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, stall_cnt_o=1. Same with idex_rt_i=0 -> no stall.
3. branch_taken_i=1 for 1 cycle, no hazards -> ifid_flush_o=1, flush_cnt_o=1. branch_taken_i and load_use together -> stall only, flush_cnt_o unchanged.
4. dmem_req_i=1, dmem_ack_i=0 for 3 cycles, then ack=1 -> state_o=2 after first edge. All writes 0 and memwb_bubble_o=1 for 3 cycles. Released on ack cycle, state_o=1 next, stall_cnt_o=3.
5. dmem_req_i=1, ack=0 held 20 cycles (MEM_TIMEOUT=16) -> state_o=3 and err_o=1 after the 16th wait edge, pipeline frozen. rst_i=0 one edge -> state_o=0, err_o=0.
6. CNT_W=4: 20 load-use cycles -> stall_cnt_o saturates at 15.
